// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Purpose:
//   This block produces the fetch-redirect controls for the instruction
//   memory / PC unit. It decodes beq, bne, j, jal and jr from the word that
//   is currently being fetched. The redirect is issued one cycle later, in
//   the MIPS delay-slot cycle, and never in the branch cycle itself.
//   All outputs are combinational from the FSM state, the pending redirect
//   registers and the current inputs. The PC unit samples them at the next
//   rising edge of clk.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-low reset (asserted when 0)
//   pc              byte address of the instruction currently fetched
//   instruction     instruction word at pc
//   rs_data         forwarded rs operand of the current instruction
//   rt_data         forwarded rt operand of the current instruction
//   stall           pipeline hold request; fetch must not advance
//   absJump         absolute redirect this cycle
//   absJumpAddress  absolute target in bytes; valid while absJump=1, else 0
//   relJumpDelta    extra signed word delta added to PC+1
//   link_write      jal link-register write strobe
//   link_reg        link register index, always LINK_REG
//   link_addr       return address, pc+8
//   in_delay_slot   the current cycle is a delay slot; this is also the
//                   externally visible FSM state (1 = SLOT)
//   slot_violation  one-cycle pulse: control instruction found in a slot
//
// Handshake: this block has no valid/ready pairs. stall is a level-sensitive
// hold. While stall=1, neither the FSM nor the pending registers move, and
// the PC unit is told to re-fetch the same word (relJumpDelta=HOLD_DELTA).
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter logic [4:0]  LINK_REG   = 5'd31,
  parameter logic [15:0] HOLD_DELTA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  output logic        absJump,
  output logic [31:0] absJumpAddress,
  output logic [15:0] relJumpDelta,
  output logic        link_write,
  output logic [4:0]  link_reg,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        slot_violation
);

  // -------------------------------------------------------------------------
  // Opcode / funct encodings
  // -------------------------------------------------------------------------
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    CTRL_NONE,
    CTRL_BEQ,
    CTRL_BNE,
    CTRL_J,
    CTRL_JAL,
    CTRL_JR
  } ctrl_e;

  // -------------------------------------------------------------------------
  // State and pending redirect registers
  // -------------------------------------------------------------------------
  state_e      state, state_next;
  logic        p_taken, p_taken_next;
  logic        p_abs, p_abs_next;
  logic [31:0] p_addr, p_addr_next;
  logic [15:0] p_delta, p_delta_next;

  // -------------------------------------------------------------------------
  // Decode of the currently fetched word
  // -------------------------------------------------------------------------
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;
  ctrl_e       ctrl;
  logic        is_ctrl;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];

  always_comb begin
    ctrl = CTRL_NONE;
    case (opcode)
      OPC_BEQ:     ctrl = CTRL_BEQ;
      OPC_BNE:     ctrl = CTRL_BNE;
      OPC_J:       ctrl = CTRL_J;
      OPC_JAL:     ctrl = CTRL_JAL;
      OPC_SPECIAL: if (funct == FUNCT_JR) ctrl = CTRL_JR;
      default:     ctrl = CTRL_NONE;
    endcase
  end

  assign is_ctrl = (ctrl != CTRL_NONE);

  // -------------------------------------------------------------------------
  // Candidate pending values for a branch/jump found in the current word.
  //
  // The branch target is (branch_pc+4) + 4*imm. The redirect is applied at
  // the delay slot (branch_pc+4), and the PC unit adds 1 word by itself, so
  // the delta needed there is imm-1. This wraps modulo 2^16, so imm=0x8000
  // gives 0x7FFF.
  // -------------------------------------------------------------------------
  logic [15:0] br_delta;
  logic [31:0] j_target;
  logic        operands_equal;

  assign br_delta       = imm16 - 16'd1;
  assign j_target       = {pc[31:28], instruction[25:0], 2'b00};
  assign operands_equal = (rs_data == rt_data);

  // Link outputs do not depend on state; only the strobe is qualified.
  assign link_reg      = LINK_REG;
  assign link_addr     = pc + 32'd8;
  assign in_delay_slot = (state == SLOT);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    state   <= state_next;
    p_taken <= p_taken_next;
    p_abs   <= p_abs_next;
    p_addr  <= p_addr_next;
    p_delta <= p_delta_next;
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    p_taken_next   = p_taken;
    p_abs_next     = p_abs;
    p_addr_next    = p_addr;
    p_delta_next   = p_delta;
    absJump        = 1'b0;
    absJumpAddress = 32'd0;
    relJumpDelta   = 16'd0;
    link_write     = 1'b0;
    slot_violation = 1'b0;

    if (!reset) begin
      // Any in-flight slot is dropped, so no redirect ever follows a reset.
      // The redirect outputs stay at their zero defaults.
      state_next   = IDLE;
      p_taken_next = 1'b0;
      p_abs_next   = 1'b0;
      p_addr_next  = 32'd0;
      p_delta_next = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (stall) begin
            relJumpDelta = HOLD_DELTA;
          end else if (is_ctrl) begin
            // Fetch advances normally into the delay slot (delta 0).
            state_next = SLOT;
            case (ctrl)
              CTRL_BEQ, CTRL_BNE: begin
                p_taken_next = (ctrl == CTRL_BEQ) ? operands_equal
                                                  : !operands_equal;
                p_abs_next   = 1'b0;
                p_delta_next = br_delta;
              end
              CTRL_J, CTRL_JAL: begin
                p_taken_next = 1'b1;
                p_abs_next   = 1'b1;
                p_addr_next  = j_target;
                link_write   = (ctrl == CTRL_JAL);
              end
              CTRL_JR: begin
                // The register target is used as-is, even if it is unaligned.
                p_taken_next = 1'b1;
                p_abs_next   = 1'b1;
                p_addr_next  = rs_data;
              end
              default: begin
                p_taken_next = 1'b0;
              end
            endcase
          end
        end

        SLOT: begin
          if (stall) begin
            relJumpDelta = HOLD_DELTA;
          end else begin
            // A control word in the slot is not decoded. It is only flagged.
            slot_violation = is_ctrl;
            state_next     = IDLE;
            if (p_taken && p_abs) begin
              absJump        = 1'b1;
              absJumpAddress = p_addr;
            end else if (p_taken) begin
              relJumpDelta = p_delta;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// The bench drives branch_redirect_ctrl through directed scenarios and then
// through a randomized instruction stream. The PC follows the redirect that
// the reference model predicts. The reference model tracks the pending
// redirect as a target byte address. It derives the slot delta from that
// address, so it does not copy the imm-1 formula used in the RTL.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  // -------------------------------------------------------------------------
  // Clock and DUT signals
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        absJump;
  logic [31:0] absJumpAddress;
  logic [15:0] relJumpDelta;
  logic        link_write;
  logic [4:0]  link_reg;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        slot_violation;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instruction    (instruction),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .stall          (stall),
    .absJump        (absJump),
    .absJumpAddress (absJumpAddress),
    .relJumpDelta   (relJumpDelta),
    .link_write     (link_write),
    .link_reg       (link_reg),
    .link_addr      (link_addr),
    .in_delay_slot  (in_delay_slot),
    .slot_violation (slot_violation)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and sampled outputs
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic        o_abs, o_lw, o_ids, o_sv;
  logic [31:0] o_addr, o_la;
  logic [15:0] o_delta;

  // -------------------------------------------------------------------------
  // Reference model state: an outstanding redirect that is still waiting for
  // its delay slot.
  // -------------------------------------------------------------------------
  bit          m_wait;
  bit          m_taken;
  bit          m_is_abs;
  logic [31:0] m_target;
  logic [31:0] m_branch_pc;
  logic [31:0] pc_next;

  localparam logic [31:0] NOP = 32'h0000_0020;  // add $0,$0,$0

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic logic [31:0] mk_jr();
    return {6'd0, 5'd3, 15'd0, 6'b001000};
  endfunction

  // Instruction kind: 0 none, 1 beq, 2 bne, 3 j, 4 jal, 5 jr.
  function automatic int kind_of(input logic [31:0] ins);
    if (ins[31:26] == 6'd4) return 1;
    if (ins[31:26] == 6'd5) return 2;
    if (ins[31:26] == 6'd2) return 3;
    if (ins[31:26] == 6'd3) return 4;
    if (ins[31:26] == 6'd0 && ins[5:0] == 6'd8) return 5;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // One clock cycle. The inputs are driven at negedge, the outputs are
  // checked 1 ns later, and the model advances at the following posedge.
  // -------------------------------------------------------------------------
  task automatic step(input logic rst, input logic st, input logic [31:0] ins,
                      input logic [31:0] rs, input logic [31:0] rt);
    logic        e_abs, e_lw, e_sv;
    logic [31:0] e_addr, diff;
    logic [15:0] e_delta;
    int          k;
    @(negedge clk);
    pc          = pc_next;
    reset       = rst;
    stall       = st;
    instruction = ins;
    rs_data     = rs;
    rt_data     = rt;
    #1;
    k       = kind_of(ins);
    e_abs   = 1'b0;
    e_addr  = 32'd0;
    e_delta = 16'd0;
    e_lw    = 1'b0;
    e_sv    = 1'b0;
    if (rst) begin
      if (st) begin
        e_delta = 16'hFFFF;
      end else if (!m_wait) begin
        e_lw = (k == 4);
      end else begin
        e_sv = (k != 0);
        if (m_taken && m_is_abs) begin
          e_abs  = 1'b1;
          e_addr = m_target;
        end else if (m_taken) begin
          // The target must equal slot_pc + 4 + 4*delta.
          diff    = m_target - (pc + 32'd4);
          e_delta = diff[17:2];
        end
      end
    end
    o_abs = absJump; o_addr = absJumpAddress; o_delta = relJumpDelta;
    o_lw = link_write; o_la = link_addr; o_ids = in_delay_slot; o_sv = slot_violation;
    check("absJump", {31'd0, absJump}, {31'd0, e_abs});
    if (e_abs) check("absJumpAddress", absJumpAddress, e_addr);
    check("relJumpDelta", {16'd0, relJumpDelta}, {16'd0, e_delta});
    check("link_write", {31'd0, link_write}, {31'd0, e_lw});
    check("link_reg", {27'd0, link_reg}, 32'd31);
    check("link_addr", link_addr, pc + 32'd8);
    check("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, m_wait});
    check("slot_violation", {31'd0, slot_violation}, {31'd0, e_sv});
    @(posedge clk);
    if (!rst) begin
      m_wait = 0;
      m_taken = 0;
      m_is_abs = 0;
    end else if (!st) begin
      if (m_wait) begin
        m_wait = 0;
      end else if (k != 0) begin
        m_wait      = 1;
        m_branch_pc = pc;
        case (k)
          1, 2: begin
            m_taken  = (k == 1) ? (rs == rt) : (rs != rt);
            m_is_abs = 0;
            m_target = pc + 32'd4 + ({{16{ins[15]}}, ins[15:0]} << 2);
          end
          3, 4: begin
            m_taken  = 1;
            m_is_abs = 1;
            m_target = {pc[31:28], ins[25:0], 2'b00};
          end
          default: begin
            m_taken  = 1;
            m_is_abs = 1;
            m_target = rs;
          end
        endcase
      end
    end
    // The next fetch address follows the predicted outputs.
    if (rst && st) pc_next = pc;
    else if (e_abs) pc_next = e_addr;
    else pc_next = pc + 32'd4 + {{14{e_delta[15]}}, e_delta, 2'b00};
  endtask

  // -------------------------------------------------------------------------
  // Directed steps followed by random stimulus
  // -------------------------------------------------------------------------
  initial begin
    m_wait = 0; m_taken = 0; m_is_abs = 0; m_target = '0; m_branch_pc = '0;
    pc_next = 32'h0000_2000;
    pc = '0; reset = 1'b0; stall = 1'b0; instruction = NOP; rs_data = '0; rt_data = '0;

    // Reset low for 2 cycles, then a non-control stream.
    step(1'b0, 1'b0, NOP, 0, 0);
    step(1'b0, 1'b0, NOP, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, NOP, 0, 0);
      check("rst_abs", {31'd0, o_abs}, 32'd0);
      check("rst_delta", {16'd0, o_delta}, 32'd0);
      check("rst_slot", {31'd0, o_ids}, 32'd0);
    end

    // beq at 0x3000, imm=3, taken.
    pc_next = 32'h0000_3000;
    step(1'b1, 1'b0, mk_i(6'd4, 16'd3), 5, 5);
    check("beq_branch_delta", {16'd0, o_delta}, 32'd0);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("beq_slot_delta", {16'd0, o_delta}, 32'h0002);
    check("beq_slot_flag", {31'd0, o_ids}, 32'd1);
    check("beq_next_pc", pc_next, 32'h0000_3010);

    // bne imm=-2: not taken, then taken.
    step(1'b1, 1'b0, mk_i(6'd5, 16'hFFFE), 7, 7);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("bne_nt_delta", {16'd0, o_delta}, 32'd0);
    step(1'b1, 1'b0, mk_i(6'd5, 16'hFFFE), 7, 9);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("bne_t_delta", {16'd0, o_delta}, 32'h0000_FFFD);

    // Delta boundaries imm=0 and imm=0x8000.
    pc_next = 32'h0000_3000;
    step(1'b1, 1'b0, mk_i(6'd4, 16'h0000), 1, 1);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("imm0_delta", {16'd0, o_delta}, 32'h0000_FFFF);
    pc_next = 32'h0004_0000;
    step(1'b1, 1'b0, mk_i(6'd4, 16'h8000), 1, 1);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("imm8000_delta", {16'd0, o_delta}, 32'h0000_7FFF);

    // jal at 0x3008, index 0x0C05.
    pc_next = 32'h0000_3008;
    step(1'b1, 1'b0, mk_j(6'd3, 26'h0000C05), 0, 0);
    check("jal_link_write", {31'd0, o_lw}, 32'd1);
    check("jal_link_addr", o_la, 32'h0000_3010);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("jal_abs", {31'd0, o_abs}, 32'd1);
    check("jal_addr", o_addr, 32'h0000_3014);

    // jr to 0x3040, stalled for 2 cycles in the slot.
    step(1'b1, 1'b0, mk_jr(), 32'h0000_3040, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, NOP, 0, 0);
      check("jr_stall_delta", {16'd0, o_delta}, 32'h0000_FFFF);
      check("jr_stall_abs", {31'd0, o_abs}, 32'd0);
    end
    step(1'b1, 1'b0, NOP, 0, 0);
    check("jr_abs", {31'd0, o_abs}, 32'd1);
    check("jr_addr", o_addr, 32'h0000_3040);

    // j with a beq in its slot.
    pc_next = 32'h0000_3000;
    step(1'b1, 1'b0, mk_j(6'd2, 26'h0000800), 0, 0);
    step(1'b1, 1'b0, mk_i(6'd4, 16'd5), 1, 1);
    check("viol_pulse", {31'd0, o_sv}, 32'd1);
    check("viol_abs_addr", o_addr, 32'h0000_2000);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("viol_clear", {31'd0, o_sv}, 32'd0);
    check("viol_no_slot", {31'd0, o_ids}, 32'd0);
    check("viol_beq_ignored", {16'd0, o_delta}, 32'd0);

    // Reset asserted while a slot is in flight.
    step(1'b1, 1'b0, mk_j(6'd2, 26'h0000900), 0, 0);
    step(1'b0, 1'b0, NOP, 0, 0);
    check("rst_slot_abs", {31'd0, o_abs}, 32'd0);
    step(1'b1, 1'b0, NOP, 0, 0);
    check("rst_slot_idle", {31'd0, o_ids}, 32'd0);
    check("rst_slot_noabs", {31'd0, o_abs}, 32'd0);

    // Randomized stream.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins, rs, rt;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: ins = mk_i(6'd4, 16'($urandom));
        1: ins = mk_i(6'd5, 16'($urandom));
        2: ins = mk_j(6'd2, 26'($urandom));
        3: ins = mk_j(6'd3, 26'($urandom));
        4: ins = mk_jr();
        5: ins = {6'd0, 20'($urandom), 6'($urandom_range(9, 63))};
        default: ins = {6'($urandom_range(6, 63)), 26'($urandom)};
      endcase
      rs = 32'($urandom_range(0, 3));
      rt = 32'($urandom_range(0, 3));
      if (sel == 4) rs = $urandom;
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0), ins, rs, rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
